// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic blocks.
// Holds the control FSM state encoding and the bit-counter width helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefaultWidth = 4;

  // Counter width for the default operand width; instances derive theirs via cnt_width().
  localparam int unsigned CNT_W = $clog2(DefaultWidth);

  function automatic int unsigned cnt_width(int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result bus of the serial subtractor.
// The sequencer drives the master side; the subtractor sits on the slave side.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (
    output start,
    output a,
    output b,
    output bin,
    input  busy,
    input  done,
    input  d,
    input  bout
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  bin,
    output busy,
    output done,
    output d,
    output bout
  );

endinterface

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational one-bit full subtractor: diff = x - y - bi, bo set on underflow.
module fs_cell (
  input  logic x_i,
  input  logic y_i,
  input  logic bi_i,
  output logic diff_o,
  output logic bo_o
);

  logic x_xor_y;

  assign x_xor_y = x_i ^ y_i;
  assign diff_o  = x_xor_y ^ bi_i;
  assign bo_o    = (~x_i & y_i) | (~x_xor_y & bi_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: D = A - B - Bin, one bit per cycle, LSB first.
// A single fs_cell is reused every cycle; the borrow between bits lives in br_q.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned   CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             diff;
  logic             nbr;
  logic             accept;

  fs_cell u_fs_cell (
    .x_i    (ra_q[0]),
    .y_i    (rb_q[0]),
    .bi_i   (br_q),
    .diff_o (diff),
    .bo_o   (nbr)
  );

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    sr_d    = sr_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    accept  = 1'b0;

    unique case (state_q)
      StIdle: begin
        accept = bus.start;
      end
      StRun: begin
        ra_d = {1'b0, ra_q[WIDTH-1:1]};
        rb_d = {1'b0, rb_q[WIDTH-1:1]};
        sr_d = {diff, sr_q[WIDTH-1:1]};
        br_d = nbr;
        if (cnt_q == LastCnt) begin
          // Last bit: sr_d already holds the full difference in place.
          d_d     = sr_d;
          bout_d  = nbr;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        accept = bus.start;
        if (!bus.start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      ra_d    = bus.a;
      rb_d    = bus.b;
      br_d    = bus.bin;
      sr_d    = '0;
      cnt_d   = '0;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      sr_q    <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      sr_q    <= sr_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StDone);
  assign bus.d    = d_q;
  assign bus.bout = bout_q;

  // The oldest shifted-out bit is dropped on every shift and never observed.
  logic unused_sr_lsb;
  assign unused_sr_lsb = sr_q[0];

  a_busy_done_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(bus.busy && bus.done));

  a_cnt_in_range : assert property (@(posedge clk) disable iff (rst)
    cnt_q <= LastCnt);

endmodule
